// File: rtl/at_uart_pkg.sv
// Shared state encoding, constants and baud helper for the AT-path UART transmitter.
// Build option AT_UART_TX_PARITY_EN adds an even-parity bit after the data bits.
package at_uart_pkg;

   localparam logic        UART_IDLE_LVL  = 1'b1;
   localparam int unsigned UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef AT_UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } tx_state_e;

   function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/at_uart_fifo.sv
// Single-clock byte FIFO feeding the UART shifter; DEPTH must be a power of two.
module at_uart_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; count and pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/at_uart_tx.sv
// FIFO-buffered UART transmitter (8N1) for the AT/MQTT byte stream toward the Wi-Fi module.
// Build option AT_UART_TX_PARITY_EN inserts an even-parity bit, giving 11-bit frames.
module at_uart_tx
   import at_uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic       txd,
   output logic       busy,
   output logic       overflow
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(UART_DATA_BITS - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("at_uart_tx: CLK_FREQ / BAUD must be at least 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("at_uart_tx: FIFO_DEPTH must be a power of two and at least 2");
   end

   tx_state_e                 state_q, state_d;
   logic [CNT_W-1:0]          baud_cnt_q, baud_cnt_d;
   logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      txd_q, txd_d;
   logic                      overflow_q, overflow_d;
`ifdef AT_UART_TX_PARITY_EN
   logic                      parity_q, parity_d;
`endif

   logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [UART_DATA_BITS-1:0] fifo_rdata;
   logic                      bit_done;

   // Ready is forced low during reset so nothing is accepted on a reset edge.
   assign byte_ready = !fifo_full && !rst;
   assign fifo_push  = byte_valid && byte_ready;
   assign bit_done   = (baud_cnt_q == CNT_MAX);

   at_uart_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .wdata_i (byte_in),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      fifo_pop  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            if (bit_done) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (bit_done) begin
               bit_idx_d = bit_idx_q + 1'b1;
               shift_d   = shift_q >> 1;
               if (bit_idx_q == LAST_BIT) begin
`ifdef AT_UART_TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef AT_UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_done) state_d = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (bit_done) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  state_d  = ST_START;
               end else begin
                  state_d  = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (fifo_pop) shift_d = fifo_rdata;

      // Restart the bit timer on every bit boundary and every state change.
      if (state_q == ST_IDLE || bit_done || state_d != state_q) baud_cnt_d = '0;
      else                                                    baud_cnt_d = baud_cnt_q + 1'b1;

`ifdef AT_UART_TX_PARITY_EN
      parity_d = fifo_pop ? ^fifo_rdata : parity_q;
`endif

      case (state_d)
         ST_START:  txd_d = 1'b0;
         ST_DATA:   txd_d = shift_d[0];
`ifdef AT_UART_TX_PARITY_EN
         ST_PARITY: txd_d = parity_q;
`endif
         default:   txd_d = UART_IDLE_LVL;
      endcase

      overflow_d = overflow_q || (byte_valid && fifo_full);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         txd_q      <= UART_IDLE_LVL;
         overflow_q <= 1'b0;
`ifdef AT_UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         txd_q      <= txd_d;
         overflow_q <= overflow_d;
`ifdef AT_UART_TX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign txd      = txd_q;
   assign overflow = overflow_q;
   assign busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_at_uart_tx.sv
// Directed bench for at_uart_tx at 8 clocks per bit: reset, single byte, stream,
// backpressure, overflow and reset in the middle of a frame.
`timescale 1ns/1ps
module tb_at_uart_tx;

   localparam int CPB = 8;
`ifdef AT_UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int FRAME_CYC = FB * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic       byte_ready;
   logic       txd;
   logic       busy;
   logic       overflow;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0] stream_data [7]  = '{8'h5C, 8'h22, 8'h7D, 8'h7D, 8'h5D, 8'h7D, 8'h22};
   logic [7:0] bp_data     [20] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h7E,
                                    8'h81, 8'h0F, 8'hF0, 8'h33, 8'hCC, 8'h12, 8'h34,
                                    8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1};
   int starts [20];
   int stalls;
   int first_stall;
   int push_cyc;
   int lows;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   at_uart_tx #(
      .CLK_FREQ   (8),
      .BAUD       (1),
      .FIFO_DEPTH (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .txd        (txd),
      .busy       (busy),
      .overflow   (overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected line levels, index 0 = start bit, sent first.
   function automatic logic [FB-1:0] frame_bits(input logic [7:0] d);
      logic [FB-1:0] f;
      f[0]   = 1'b0;
      f[8:1] = d;
`ifdef AT_UART_TX_PARITY_EN
      f[9]   = ^d;
      f[10]  = 1'b1;
`else
      f[9]   = 1'b1;
`endif
      return f;
   endfunction

   // Presents one byte; valid drops only while the DUT is stalling.
   task automatic push_byte(input logic [7:0] b, output int n_stall);
      n_stall = 0;
      while (!byte_ready && n_stall < 5000) begin
         byte_valid = 1'b0;
         @(posedge clk); #1;
         n_stall++;
      end
      if (!byte_ready) check("push_ready", {31'b0, byte_ready}, 32'h1);
      byte_in    = b;
      byte_valid = 1'b1;
      @(posedge clk); #1;
   endtask

   // Waits up to max_wait falling edges for a start bit, then samples every cycle of the frame.
   task automatic rx_frame(input logic [7:0] exp, input int max_wait, input string tag,
                           output int start_at);
      logic [FB-1:0]  want, got, held;
      logic [CPB-1:0] s;
      int             n;
      want = frame_bits(exp);
      got  = '0;
      held = '0;
      n    = 0;
      start_at = -1;
      do begin
         @(negedge clk);
         n++;
      end while (txd !== 1'b0 && n < max_wait);
      if (txd !== 1'b0) begin
         check({tag, "_start"}, {31'b0, txd}, 32'h0);
         return;
      end
      start_at = cyc;
      for (int b = 0; b < FB; b++) begin
         for (int j = 0; j < CPB; j++) begin
            if (b != 0 || j != 0) @(negedge clk);
            s[j] = txd;
         end
         got[b]  = s[CPB/2];
         held[b] = (s == {CPB{want[b]}});
      end
      check({tag, "_bits"}, 32'(got), 32'(want));
      check({tag, "_hold"}, 32'(held), 32'((1 << FB) - 1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete, failures so far %0d", n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst        = 1'b1;
      byte_valid = 1'b0;
      byte_in    = 8'h00;

      // Reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_txd",   {31'b0, txd},        32'h1);
      check("rst_busy",  {31'b0, busy},       32'h0);
      check("rst_ready", {31'b0, byte_ready}, 32'h0);
      check("rst_ovf",   {31'b0, overflow},   32'h0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", {31'b0, byte_ready}, 32'h1);

      // Single byte 0x41
      push_byte(8'h41, stalls);
      byte_valid = 1'b0;
      push_cyc = cyc;
      check("single_busy_early", {31'b0, busy}, 32'h1);
      check("single_txd_pre",    {31'b0, txd},  32'h1);
      rx_frame(8'h41, 4, "single", starts[0]);
      check("single_latency", starts[0] - push_cyc, 32'd1);
      check("single_busy_last", {31'b0, busy}, 32'h1);
      @(negedge clk);
      check("single_busy_drop", {31'b0, busy}, 32'h0);
      check("single_txd_idle",  {31'b0, txd},  32'h1);

      // Back-to-back trailer stream
      @(posedge clk); #1;
      fork
         begin
            for (int i = 0; i < 7; i++) push_byte(stream_data[i], stalls);
            byte_valid = 1'b0;
         end
         begin
            for (int i = 0; i < 7; i++)
               rx_frame(stream_data[i], (i == 0) ? 8 : 1, $sformatf("stream%0d", i), starts[i]);
         end
      join
      check("stream_span", starts[6] - starts[0], 32'(6 * FRAME_CYC));
      @(negedge clk);
      check("stream_busy_end", {31'b0, busy}, 32'h0);

      // Backpressure: 20 bytes into a 16-entry FIFO
      @(posedge clk); #1;
      first_stall = -1;
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               push_byte(bp_data[i], stalls);
               if (stalls > 0 && first_stall < 0) first_stall = i;
            end
            byte_valid = 1'b0;
         end
         begin
            for (int i = 0; i < 20; i++)
               rx_frame(bp_data[i], (i == 0) ? 8 : 1, $sformatf("bp%0d", i), starts[i]);
         end
      join
      check("bp_first_stall", first_stall, 32'd17);
      check("bp_overflow", {31'b0, overflow}, 32'h0);
      @(negedge clk);
      check("bp_busy_end", {31'b0, busy}, 32'h0);

      // Overflow: valid while full, content must be preserved
      @(posedge clk); #1;
      fork
         begin
            for (int i = 0; i < 17; i++) push_byte(bp_data[i], stalls);
            byte_in    = 8'hEE;
            byte_valid = 1'b1;
            check("ovf_ready_full", {31'b0, byte_ready}, 32'h0);
            repeat (3) @(posedge clk);
            #1;
            byte_valid = 1'b0;
            check("ovf_set", {31'b0, overflow}, 32'h1);
         end
         begin
            for (int i = 0; i < 17; i++)
               rx_frame(bp_data[i], (i == 0) ? 8 : 1, $sformatf("ovf%0d", i), starts[i]);
         end
      join
      @(negedge clk);
      check("ovf_sticky",   {31'b0, overflow}, 32'h1);
      check("ovf_busy_end", {31'b0, busy},     32'h0);

      // Reset during data bit 3 of 0xA5 with four bytes queued
      @(posedge clk); #1;
      push_byte(8'hA5, stalls);
      push_byte(8'h11, stalls);
      push_byte(8'h22, stalls);
      push_byte(8'h33, stalls);
      push_byte(8'h44, stalls);
      byte_valid = 1'b0;
      repeat (32) @(posedge clk);
      #1;
      check("mid_txd_bit3", {31'b0, txd}, 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_txd",   {31'b0, txd},        32'h1);
      check("mid_rst_busy",  {31'b0, busy},       32'h0);
      check("mid_rst_ready", {31'b0, byte_ready}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_ovf_cleared", {31'b0, overflow}, 32'h0);
      lows = 0;
      for (int i = 0; i < 3 * FRAME_CYC; i++) begin
         @(negedge clk);
         if (txd !== 1'b1 || busy !== 1'b0) lows++;
      end
      check("mid_no_frames", lows, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
